turn_ctrl: RTL



---
 rtl/turn_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/turn_ctrl.sv
// Turn sequencer: reveals the selected tile, compares it with the track square ahead, then advances, passes or ends the game.
// Optional button debounce filter enabled by defining TURN_CTRL_DEBOUNCE_EN.
module turn_ctrl #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned STEP        = 1,
    parameter int unsigned SHOW_CYCLES = 25_000_000,
    parameter int unsigned DB_CYCLES   = 500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [3:0]  sel,
    input  logic [3:0]  tile_pic,
    input  logic [3:0]  target_pic,
    input  logic        W,
    output logic [1:0]  T,
    output logic [4:0]  N,
    output logic        B,
    output logic [3:0]  tile_idx,
    output logic [11:0] revealed,
    output logic        match_flag,
    output logic        busy,
    output logic        game_over
);

    localparam int unsigned NUM_TILES = 12;
    localparam int unsigned SHOW_W    = $clog2(SHOW_CYCLES + 1);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || SHOW_CYCLES < 1 || DB_CYCLES < 1) begin : g_param_err
        $error("turn_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_SHOW, S_ADV, S_SETTLE, S_PASS, S_OVER
    } state_e;

    // Button synchronizer and rising-edge detector
    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic lvl_prev_q, lvl_prev_d;
    logic btn_lvl, press;

`ifdef TURN_CTRL_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_lvl_q, db_lvl_d;

    // Accept a new level only after it differs from the filtered one for DB_CYCLES clocks in a row
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) db_lvl_d = sync2_q;
            else                                  db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign press = btn_lvl & ~lvl_prev_q;

    always_comb begin
        sync1_d    = btn;
        sync2_d    = sync1_q;
        lvl_prev_d = btn_lvl;
    end

    state_e              state_q, state_d;
    logic [SHOW_W-1:0]   show_cnt_q, show_cnt_d;
    logic                settle_q, settle_d;
    logic [1:0]          t_q, t_d;
    logic [4:0]          n_q, n_d;
    logic                b_q, b_d;
    logic [3:0]          tile_idx_q, tile_idx_d;
    logic [11:0]         revealed_q, revealed_d;
    logic                match_q, match_d;
    logic                busy_q, busy_d;
    logic                over_q, over_d;
    logic [15:0]         rev_ext;

    assign rev_ext = {4'b0, revealed_q};

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        show_cnt_d = show_cnt_q;
        settle_d   = settle_q;
        t_d        = t_q;
        tile_idx_d = tile_idx_q;
        revealed_d = revealed_q;
        match_d    = match_q;
        over_d     = over_q;

        unique case (state_q)
            S_IDLE: begin
                if (press && sel < 4'(NUM_TILES) && !rev_ext[sel]) begin
                    tile_idx_d = sel;
                    state_d    = S_CMP;
                end
            end
            S_CMP: begin
                match_d    = (tile_pic == target_pic);
                revealed_d = revealed_q | 12'(16'b1 << tile_idx_q);
                show_cnt_d = '0;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                if (show_cnt_q == SHOW_W'(SHOW_CYCLES - 1)) state_d = match_q ? S_ADV : S_PASS;
                else                                        show_cnt_d = show_cnt_q + SHOW_W'(1);
            end
            S_ADV: begin
                settle_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // W is valid on the second settle cycle; a full board ends the turn
                if (!settle_q)          settle_d = 1'b1;
                else if (W) begin
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end
                else if (&revealed_q)   state_d = S_PASS;
                else                    state_d = S_IDLE;
            end
            S_PASS: begin
                t_d        = (t_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : t_q + 2'd1;
                revealed_d = '0;
                state_d    = S_IDLE;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase

        b_d    = (state_d == S_ADV);
        n_d    = b_d ? 5'(STEP) : 5'd0;
        busy_d = !(state_d == S_IDLE || state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            show_cnt_q <= '0;
            settle_q   <= 1'b0;
            t_q        <= '0;
            n_q        <= '0;
            b_q        <= 1'b0;
            tile_idx_q <= '0;
            revealed_q <= '0;
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
            state_q    <= state_d;
            show_cnt_q <= show_cnt_d;
            settle_q   <= settle_d;
            t_q        <= t_d;
            n_q        <= n_d;
            b_q        <= b_d;
            tile_idx_q <= tile_idx_d;
            revealed_q <= revealed_d;
            match_q    <= match_d;
            busy_q     <= busy_d;
            over_q     <= over_d;
        end
    end

    assign T          = t_q;
    assign N          = n_q;
    assign B          = b_q;
    assign tile_idx   = tile_idx_q;
    assign revealed   = revealed_q;
    assign match_flag = match_q;
    assign busy       = busy_q;
    assign game_over  = over_q;

endmodule
